// File: rtl/mips_debug_pkg.sv
// Shared constants for the MIPS pipeline debug dump path: latch bus widths,
// frame header, FSM state encoding and frame lengths.
// Optional feature macro: DEBUG_DUMP_CHECKSUM_EN (appends an XOR checksum byte).
package mips_debug_pkg;

    // Pipeline latch observation bus widths (must match the pipeline top)
    localparam int NB_IF_ID  = 64;
    localparam int NB_ID_EX  = 192;
    localparam int NB_EX_MEM = 128;
    localparam int NB_MEM_WB = 64;
    localparam int NB_BYTE   = 8;

    // Snapshot geometry: 448 bits = 56 payload bytes
    localparam int NB_SHADOW = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
    localparam int N_PAYLOAD = NB_SHADOW / NB_BYTE;
    localparam int NB_INDEX  = 6;

    localparam logic [NB_BYTE-1:0] DUMP_HEADER = 8'hA5;

    // FSM encoding
    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_SEND = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    // Frame lengths in bytes: header + payload (+ checksum)
    localparam int FRAME_LEN_PLAIN    = N_PAYLOAD + 1;
    localparam int FRAME_LEN_CHECKSUM = N_PAYLOAD + 2;

endpackage

// File: rtl/dump_byte_mux.sv
// Selects frame byte [index] from the frozen snapshot: index 0 is the header,
// 1..56 are snapshot bytes MSB first, 57 is the checksum when
// DEBUG_DUMP_CHECKSUM_EN is defined. Any other index yields zero.
module dump_byte_mux
    import mips_debug_pkg::*;
(
    input  logic [NB_SHADOW-1:0] shadow,
    input  logic [NB_INDEX-1:0]  index,
`ifdef DEBUG_DUMP_CHECKSUM_EN
    input  logic [NB_BYTE-1:0]   checksum,
`endif
    output logic [NB_BYTE-1:0]   sel_byte
);

    // Byte selection by frame position
    always_comb begin
        sel_byte = '0;
        if (index == '0) begin
            sel_byte = DUMP_HEADER;
        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        if (index == NB_INDEX'(N_PAYLOAD + 1)) begin
            sel_byte = checksum;
        end
`endif
        for (int k = 1; k <= N_PAYLOAD; k++) begin
            if (index == NB_INDEX'(k)) begin
                sel_byte = shadow[(N_PAYLOAD - k) * NB_BYTE +: NB_BYTE];
            end
        end
    end

endmodule

// File: rtl/debug_latch_dump.sv
// Freezes the four pipeline latch buses on i_snap and streams them as a framed
// byte sequence (0xA5 header, 56 payload bytes MSB first, optional checksum)
// over a valid/ready byte interface.
// Optional feature macro: DEBUG_DUMP_CHECKSUM_EN.
//
// Handshake: o_tx_valid/o_tx_data form a valid/ready source. A byte moves on
// any rising edge where o_tx_valid and i_tx_ready are both 1; while valid is
// high and ready is low, o_tx_data is held and valid stays high.
module debug_latch_dump
    import mips_debug_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NB_IF_ID-1:0]  i_if_id,
    input  logic [NB_ID_EX-1:0]  i_id_ex,
    input  logic [NB_EX_MEM-1:0] i_ex_mem,
    input  logic [NB_MEM_WB-1:0] i_mem_wb,
    input  logic                 i_snap,
    input  logic                 i_tx_ready,
    output logic [NB_BYTE-1:0]   o_tx_data,
    output logic                 o_tx_valid,
    output logic                 o_busy,
    output logic                 o_done
);

`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam logic [NB_INDEX-1:0] LAST_INDEX = NB_INDEX'(FRAME_LEN_CHECKSUM - 1);
`else
    localparam logic [NB_INDEX-1:0] LAST_INDEX = NB_INDEX'(FRAME_LEN_PLAIN - 1);
`endif
    localparam logic [NB_INDEX-1:0] FIRST_PAYLOAD = NB_INDEX'(1);
    localparam logic [NB_INDEX-1:0] LAST_PAYLOAD  = NB_INDEX'(N_PAYLOAD);

    logic [1:0]           state;
    logic [NB_SHADOW-1:0] shadow;
    logic [NB_INDEX-1:0]  index;
    logic [NB_INDEX-1:0]  next_index;
    logic [NB_BYTE-1:0]   next_byte;
    logic                 transfer;
    logic                 is_payload;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0]   checksum;
    logic [NB_BYTE-1:0]   checksum_next;
`endif

    assign transfer   = (state == STATE_SEND) && i_tx_ready;
    assign next_index = index + NB_INDEX'(1);
    assign is_payload = (index >= FIRST_PAYLOAD) && (index <= LAST_PAYLOAD);

    assign o_tx_valid = (state == STATE_SEND);
    assign o_busy     = (state != STATE_IDLE);
    assign o_done     = (state == STATE_DONE);

`ifdef DEBUG_DUMP_CHECKSUM_EN
    // Folds the byte on the wire into the checksum; the mux sees this value so
    // the checksum byte already includes the last payload byte.
    assign checksum_next = is_payload ? (checksum ^ o_tx_data) : checksum;
`endif

    // Byte for the position after the current one, loaded on a transfer
    dump_byte_mux u_byte_mux (
        .shadow   (shadow),
        .index    (next_index),
`ifdef DEBUG_DUMP_CHECKSUM_EN
        .checksum (checksum_next),
`endif
        .sel_byte (next_byte)
    );

    // Capture / send / done sequencing with registered output byte
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= STATE_IDLE;
            shadow    <= '0;
            index     <= '0;
            o_tx_data <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (i_snap) begin
                        shadow    <= {i_if_id, i_id_ex, i_ex_mem, i_mem_wb};
                        index     <= '0;
                        o_tx_data <= DUMP_HEADER;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        checksum  <= '0;
`endif
                        state     <= STATE_SEND;
                    end
                end
                STATE_SEND: begin
                    if (transfer) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        checksum <= checksum_next;
`endif
                        if (index == LAST_INDEX) begin
                            o_tx_data <= '0;
                            state     <= STATE_DONE;
                        end else begin
                            index     <= next_index;
                            o_tx_data <= next_byte;
                        end
                    end
                end
                STATE_DONE: begin
                    state <= STATE_IDLE;
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_latch_dump.sv
// Bench for debug_latch_dump: directed frames against a queue-based frame model.
module tb_debug_latch_dump;

`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int FRAME_LEN = 58;
`else
    localparam int FRAME_LEN = 57;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [63:0]  i_if_id;
    logic [191:0] i_id_ex;
    logic [127:0] i_ex_mem;
    logic [63:0]  i_mem_wb;
    logic         i_snap;
    logic         i_tx_ready;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         o_busy;
    logic         o_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model and scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] last_frame[$];
    logic [7:0] ref_frame[$];
    bit         m_send = 1'b0;
    bit         m_done = 1'b0;
    int         frames_done = 0;
    int         xfer_cnt = 0;

    debug_latch_dump dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_if_id    (i_if_id),
        .i_id_ex    (i_id_ex),
        .i_ex_mem   (i_ex_mem),
        .i_mem_wb   (i_mem_wb),
        .i_snap     (i_snap),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame: header, snapshot bytes MSB first, optional XOR of payload
    task automatic build_frame(input logic [63:0] a, input logic [191:0] b,
                               input logic [127:0] c, input logic [63:0] d);
        logic [447:0] snapv;
        logic [7:0]   cs;
        logic [7:0]   by;
        snapv = {a, b, c, d};
        cs = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 56; i++) begin
            by = snapv[447 - 8*i -: 8];
            cs = cs ^ by;
            exp_q.push_back(by);
        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    // Per-cycle compare against the model, then advance the model
    always @(negedge i_clk) begin
        if (!i_rst) begin
            check("rst_valid", o_tx_valid, 1'b0);
            check("rst_busy", o_busy, 1'b0);
            check("rst_done", o_done, 1'b0);
            check("rst_data", o_tx_data, 8'h00);
            exp_q.delete();
            got_q.delete();
            m_send = 1'b0;
            m_done = 1'b0;
            xfer_cnt = 0;
        end else begin
            check("valid", o_tx_valid, m_send);
            check("busy", o_busy, m_send || m_done);
            check("done", o_done, m_done);
            if (m_send) check("data", o_tx_data, exp_q[0]);
            if (o_tx_valid && i_tx_ready) begin
                got_q.push_back(o_tx_data);
                xfer_cnt++;
            end
            if (o_done) begin
                check("frame_len", xfer_cnt, FRAME_LEN);
                last_frame = got_q;
                got_q.delete();
                xfer_cnt = 0;
            end
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_send) begin
                if (i_tx_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        m_send = 1'b0;
                        m_done = 1'b1;
                        frames_done++;
                    end
                end
            end else if (i_snap) begin
                build_frame(i_if_id, i_id_ex, i_ex_mem, i_mem_wb);
                m_send = 1'b1;
            end
        end
    end

    // Waits for o_done with a cycle budget; bp applies a 1-0-0-1 ready pattern
    task automatic wait_done(input int limit, input bit bp);
        bit       seen;
        int       n;
        bit [3:0] pat;
        seen = 1'b0;
        n = 0;
        pat = 4'b1001;
        while (!seen && n < limit) begin
            @(posedge i_clk);
            #1;
            if (o_done) seen = 1'b1;
            i_tx_ready = bp ? pat[3 - (n % 4)] : 1'b1;
            n++;
        end
        check("done_timeout", seen, 1'b1);
        i_tx_ready = 1'b1;
        @(negedge i_clk);
        #1;
    endtask

    task automatic pulse_snap();
        @(posedge i_clk);
        #1 i_snap = 1'b1;
        @(posedge i_clk);
        #1 i_snap = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1_exp [0:8];
        int         frames_before;
        int         valid_seen;
        t1_exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04, 8'h20, 8'h08, 8'h00, 8'h05};

        i_rst = 1'b0;
        i_snap = 1'b0;
        i_tx_ready = 1'b1;
        i_if_id = '0;
        i_id_ex = '0;
        i_ex_mem = '0;
        i_mem_wb = '0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b1;

        // Capture with sink always ready
        i_if_id = 64'h0000_0004_2008_0005;
        pulse_snap();
        wait_done(200, 1'b0);
        check("t1_len", last_frame.size(), FRAME_LEN);
        for (int i = 0; i < 9; i++) check("t1_head_bytes", last_frame[i], t1_exp[i]);
        for (int i = 9; i < 57; i++) check("t1_zero_bytes", last_frame[i], 8'h00);
`ifdef DEBUG_DUMP_CHECKSUM_EN
        check("t1_checksum", last_frame[57], 8'h29);
`endif
        ref_frame = last_frame;

        // Backpressure, same snapshot content
        pulse_snap();
        wait_done(400, 1'b1);
        check("t2_len", last_frame.size(), ref_frame.size());
        for (int i = 0; i < FRAME_LEN; i++) check("t2_same_bytes", last_frame[i], ref_frame[i]);

        // Snapshot isolation: buses go all-ones right after capture
        i_if_id  = 64'h1122_3344_5566_7788;
        i_id_ex  = {64'h0102_0304_0506_0708, 64'h090A_0B0C_0D0E_0F10, 64'h1112_1314_1516_1718};
        i_ex_mem = {64'h2122_2324_2526_2728, 64'h3132_3334_3536_3738};
        i_mem_wb = 64'hDEAD_BEEF_CAFE_F00D;
        pulse_snap();
        i_if_id = '1;
        i_id_ex = '1;
        i_ex_mem = '1;
        i_mem_wb = '1;
        wait_done(200, 1'b0);
        check("t3_first_payload", last_frame[1], 8'h11);
        check("t3_if_id_lsb", last_frame[8], 8'h88);
        check("t3_id_ex_msb", last_frame[9], 8'h01);
        check("t3_last_payload", last_frame[56], 8'h0D);
        i_if_id = 64'h0000_0004_2008_0005;
        i_id_ex = '0;
        i_ex_mem = '0;
        i_mem_wb = '0;

        // Request held through SEND: one frame, then a new one after DONE
        frames_before = frames_done;
        @(posedge i_clk);
        #1 i_snap = 1'b1;
        @(posedge i_clk);
        #1;
        wait_done(200, 1'b0);
        check("t4_one_frame", frames_done - frames_before, 1);
        @(posedge i_clk);
        #1;
        check("t4_idle_valid", o_tx_valid, 1'b0);
        @(posedge i_clk);
        #1 i_snap = 1'b0;
        check("t4_restart_valid", o_tx_valid, 1'b1);
        check("t4_restart_header", o_tx_data, 8'hA5);
        wait_done(200, 1'b0);
        check("t4_two_frames", frames_done - frames_before, 2);
        for (int i = 0; i < FRAME_LEN; i++) check("t4_bytes", last_frame[i], ref_frame[i]);

        // Reset mid-frame after byte 10 has transferred
        i_if_id = 64'hFFEE_DDCC_BBAA_9988;
        pulse_snap();
        repeat (11) @(posedge i_clk);
        #3 i_rst = 1'b0;
        #1;
        check("t5_async_valid", o_tx_valid, 1'b0);
        check("t5_async_busy", o_busy, 1'b0);
        check("t5_async_data", o_tx_data, 8'h00);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b1;
        valid_seen = 0;
        repeat (20) begin
            @(posedge i_clk);
            #1;
            if (o_tx_valid) valid_seen++;
        end
        check("t5_no_bytes_after_release", valid_seen, 0);

        // Recovery: fresh frame after reset
        i_if_id = 64'h0000_0004_2008_0005;
        pulse_snap();
        wait_done(200, 1'b0);
        check("t6_len", last_frame.size(), FRAME_LEN);
        for (int i = 0; i < FRAME_LEN; i++) check("t6_bytes", last_frame[i], ref_frame[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_latch_dump.md
# debug_latch_dump

Debug stage downstream of the five-stage MIPS pipeline top. It consumes the four pipeline-latch observation buses (IF/ID, ID/EX, EX/MEM, MEM/WB), freezes a snapshot of all of them on request, and streams the snapshot as a framed byte sequence over a valid/ready byte interface that feeds the UART transmitter. It decouples a 448-bit wide single-cycle capture from a slow byte-serial link.

## Interface
- NB_IF_ID, 64, width of IF/ID bus
- NB_ID_EX, 192, width of ID/EX bus
- NB_EX_MEM, 128, width of EX/MEM bus
- NB_MEM_WB, 64, width of MEM/WB bus
- NB_BYTE, 8, width of output byte
- Every bus width is a multiple of NB_BYTE.
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_if_id  in  NB_IF_ID  IF/ID latch contents
- i_id_ex  in  NB_ID_EX  ID/EX latch contents
- i_ex_mem  in  NB_EX_MEM  EX/MEM latch contents
- i_mem_wb  in  NB_MEM_WB  MEM/WB latch contents
- i_snap  in  1  snapshot request, sampled each cycle
- i_tx_ready  in  1  byte sink ready
- o_tx_data  out  NB_BYTE  byte to sink
- o_tx_valid  out  1  o_tx_data valid
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse, frame complete

## Operation
- States: IDLE, SEND, DONE.
- IDLE: when i_snap=1 at a rising edge, load the shadow register {i_if_id, i_id_ex, i_ex_mem, i_mem_wb} (IF/ID in the MSBs), clear the byte index and the checksum, and go to SEND. Otherwise stay in IDLE.
- SEND: o_tx_valid=1. The frame order is:
  - byte 0: header 0xA5
  - bytes 1..56: payload, most-significant byte of the shadow register first
  - byte 57: checksum (when enabled)
- A transfer occurs on a cycle with o_tx_valid & i_tx_ready. Each transfer advances the byte index. Each payload transfer XORs that byte into the checksum.
- After the final byte transfers, go to DONE.
- DONE: lasts one cycle, with o_done=1. Then return to IDLE.
- i_snap is ignored in SEND and DONE. It is not queued.
- The shadow register never changes during SEND. Input buses may change freely after capture.
- o_busy=1 in SEND and DONE, 0 in IDLE.
- Byte index: 6-bit unsigned. Its terminal value is 56 without the checksum and 57 with it. It never wraps within a frame.

## Timing
- Reset (i_rst=0, asynchronous): state IDLE, o_tx_valid=0, o_tx_data=0, o_busy=0, o_done=0, index=0, checksum=0, shadow=0.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is retried after release.
- Latency: snapshot edge N. Then o_tx_valid=1 and o_tx_data=0xA5 from cycle N+1.
- While o_tx_valid=1 and i_tx_ready=0, o_tx_data is held stable. o_tx_valid never drops before the transfer.
- With i_tx_ready tied high, a frame occupies 57 cycles (58 with checksum) of SEND plus 1 DONE cycle. The next i_snap is accepted the cycle after DONE.
- o_tx_data is registered. It changes only on the edge following a transfer or the capture.

## Configuration
- DEBUG_DUMP_CHECKSUM_EN defined:
  - frame is 58 bytes
  - byte 57 = XOR of payload bytes 1..56; the header is excluded
- Not defined:
  - the checksum register and its logic are absent
  - frame is 57 bytes; DONE follows payload byte 56

## Structure
- Shared package mips_debug_pkg holds:
  - the four latch width constants, matching the pipeline top
  - DUMP_HEADER = 8'hA5
  - the state encoding IDLE/SEND/DONE
  - frame-length constants for both configurations
- One sub-module, dump_byte_mux: combinational selection of byte[index] from the 448-bit shadow plus header/checksum. The FSM, counters and output registers remain in debug_latch_dump.

## Test plan
- Capture with sink always ready:
  - Stimulus: i_if_id=64'h0000_0004_2008_0005, other buses zero, i_snap pulse.
  - Response: A5, then 00 00 00 04 20 08 00 05, then 48 bytes of 00. With the checksum enabled, the last byte is 29. o_done pulses in the cycle after the last byte.
- Backpressure:
  - Stimulus: i_tx_ready toggling 1-0-0-1 throughout the frame.
  - Response: o_tx_data stays stable and o_tx_valid stays high across stalls. The byte sequence is identical to the always-ready case.
- Snapshot isolation:
  - Stimulus: change every input bus to all-ones the cycle after capture.
  - Response: the transmitted payload equals the pre-change values.
- Ignored request:
  - Stimulus: i_snap held high throughout SEND.
  - Response: exactly one frame. A new frame starts only after DONE, with the header on the cycle after IDLE samples i_snap.
- Reset mid-frame:
  - Stimulus: i_rst=0 after byte 10.
  - Response: o_tx_valid, o_busy and o_tx_data go to 0 asynchronously. After release, no bytes are output until a new i_snap.
- Frame length per configuration:
  - Stimulus: count transfers per frame, ready always high.
  - Response: 58 transfers with DEBUG_DUMP_CHECKSUM_EN, 57 without.
